// File: rtl/lsu_pkg.sv
// Shared defines package for the core slice.
// Holds the ALU opcode enum, the memory access width encodings used by
// decode and the LSU, the LSU FSM state enum, and a small alignment helper.
package lsu_pkg;

  // ALU operation codes driven by decode.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLL  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9
  } alu_op_e;

  // Access width encoding shared by mem_cut (loads) and reg_cut (stores).
  typedef enum logic [1:0] {
    WIDTH_W   = 2'b00,
    WIDTH_H   = 2'b01,
    WIDTH_B   = 2'b10,
    WIDTH_INV = 2'b11
  } width_e;

  // LSU control FSM states. The encoding is also what dbg_state shows.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  // True when the byte offset is naturally aligned for the given width.
  function automatic logic is_aligned(input logic [1:0] width, input logic [1:0] off);
    case (width)
      WIDTH_W: is_aligned = (off == 2'b00);
      WIDTH_H: is_aligned = (off[0] == 1'b0);
      default: is_aligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the LSU.
// Store side: from the request width/offset and raw store data, produce the
//   bus byte enables (st_be) and the lane-replicated store data (st_lanes).
// Load side: from the registered width/offset/extension and raw bus read
//   data, produce the load result shifted to bit 0 and sign/zero extended.
// Offsets presented here are already forced aligned (low bits cleared for
// half/word), so half lanes are always 0 or 2.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_width,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_lanes,
  input  logic [1:0]  ld_width,
  input  logic [1:0]  ld_off,
  input  logic        ld_ext,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift;

  always_comb begin
    st_be    = 4'b0000;
    st_lanes = st_data;
    case (st_width)
      WIDTH_B: begin
        st_be    = 4'b0001 << st_off;
        st_lanes = {4{st_data[7:0]}};
      end
      WIDTH_H: begin
        st_be    = 4'b0011 << {st_off[1], 1'b0};
        st_lanes = {2{st_data[15:0]}};
      end
      WIDTH_W: st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  always_comb begin
    ld_shift = ld_raw >> {ld_off, 3'b000};
    case (ld_width)
      WIDTH_B: ld_data = {{24{ld_ext & ld_shift[7]}}, ld_shift[7:0]};
      WIDTH_H: ld_data = {{16{ld_ext & ld_shift[15]}}, ld_shift[15:0]};
      WIDTH_W: ld_data = ld_raw;
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: turns a decode-stage load or store into a single bus
// transaction and returns the aligned, extended load result.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_read, mem_write        load / store request from decode
//   mem_cut, reg_cut           load / store width (W=00 H=01 B=10 invalid=11)
//   ext_os                     load extension: 1 sign, 0 zero
//   addr, wdata                byte address, store data
//   stall                      hold the pipeline while a transaction is open
//   rdata, done, err           load result, completion pulse, illegal-access pulse
//   bus_*                      word-aligned request/ack memory bus
//   dbg_state                  current FSM state (lsu_state_e encoding)
// Build option: define LSU_MISALIGN_TRAP_EN to report misaligned half/word
// accesses as err; otherwise the low address bits are ignored for them.
// Bus handshake: bus_req rises the cycle after a request is accepted and all
// bus_* request fields stay constant until the cycle bus_ack is seen high;
// bus_req drops the following cycle. done and err are registered pulses.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_cut,
  input  logic [1:0]  reg_cut,
  input  logic        ext_os,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  dbg_state
);

  lsu_state_e  state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [1:0]  width_q, width_d;
  logic [1:0]  off_q, off_d;
  logic        ext_q, ext_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [1:0]  sel_cut;
  logic [1:0]  eff_off;
  logic        one_op;
  logic        legal_w;
  logic        mis_err;
  logic        accept;
  logic        bad_req;
  logic [3:0]  st_be;
  logic [31:0] st_lanes;
  logic [31:0] ld_data;

  // Request decode, only acted on in IDLE.
  always_comb begin
    sel_cut = mem_read ? mem_cut : reg_cut;
    one_op  = mem_read ^ mem_write;
    legal_w = (sel_cut != WIDTH_INV);
    // Offset actually used: half/word ignore the sub-width address bits.
    case (sel_cut)
      WIDTH_B: eff_off = addr[1:0];
      WIDTH_H: eff_off = {addr[1], 1'b0};
      default: eff_off = 2'b00;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    mis_err = one_op & legal_w & ~is_aligned(sel_cut, addr[1:0]);
`else
    mis_err = 1'b0;
`endif
    accept  = one_op & legal_w & ~mis_err;
    bad_req = (mem_read & mem_write) | ((mem_read | mem_write) & ~legal_w) | mis_err;
  end

  lsu_align u_align (
    .st_width (sel_cut),
    .st_off   (eff_off),
    .st_data  (wdata),
    .st_be    (st_be),
    .st_lanes (st_lanes),
    .ld_width (width_q),
    .ld_off   (off_q),
    .ld_ext   (ext_q),
    .ld_raw   (bus_rdata),
    .ld_data  (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    width_d     = width_q;
    off_d       = off_q;
    ext_d       = ext_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_REQ;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write;
          bus_addr_d  = {addr[31:2], 2'b00};
          bus_be_d    = st_be;
          bus_wdata_d = mem_write ? st_lanes : 32'h0;
          width_d     = sel_cut;
          off_d       = eff_off;
          ext_d       = ext_os;
        end else if (bad_req) begin
          err_d = 1'b1;
        end
      end
      ST_REQ: begin
        if (bus_ack) begin
          state_d   = ST_DONE;
          bus_req_d = 1'b0;
          done_d    = 1'b1;
          if (!bus_we_q) rdata_d = ld_data;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
      width_q     <= 2'b00;
      off_q       <= 2'b00;
      ext_q       <= 1'b0;
      rdata_q     <= 32'h0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      width_q     <= width_d;
      off_q       <= off_d;
      ext_q       <= ext_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Stall covers the accepting IDLE cycle combinationally; reset forces it low.
  assign stall     = rst_n & (((state_q == ST_IDLE) & accept) | (state_q == ST_REQ));
  assign rdata     = rdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have these ports, clock and reset first: clk  in  1  sole clock, all state on rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have mem_read  in  1  load request from decode (memRead).
REQ-003 SHALL have mem_write  in  1  store request from decode (memWrite).
REQ-004 SHALL have mem_cut  in  2  load width: 00 word, 01 half, 10 byte, 11 invalid.
REQ-005 SHALL have reg_cut  in  2  store width, same encoding as mem_cut.
REQ-006 SHALL have ext_os  in  1  load extension: 1 sign, 0 zero.
REQ-007 SHALL have addr  in  32  byte address from ALU; wdata  in  32  store data (rs2).
REQ-008 SHALL have stall  out  1  hold pipeline; rdata  out  32  aligned and extended load result; done  out  1  one-cycle completion pulse; err  out  1  one-cycle illegal-access pulse.
REQ-009 SHALL have bus_req  out  1; bus_we  out  1; bus_addr  out  32 (bits [1:0]=00); bus_be  out  4; bus_wdata  out  32; bus_ack  in  1; bus_rdata  in  32.

Function
REQ-010 SHALL implement FSM states IDLE, REQ, DONE; reset state IDLE.
REQ-011 IDLE: exactly one of mem_read or mem_write, legal width, aligned -> register addr/width/ext/lane-shifted data, go to REQ; stall=1 combinationally in that cycle.
REQ-012 IDLE with mem_read and mem_write both 1, or selected cut=11 -> err=1 for one cycle, no bus transaction, stay IDLE, stall=0.
REQ-013 Alignment: half requires addr[0]=0; word requires addr[1:0]=00; byte always aligned.
REQ-014 REQ: bus_req=1 with bus_addr, bus_we, bus_be, bus_wdata held stable until the cycle bus_ack=1; stall=1.
REQ-015 REQ with bus_ack=1 -> capture bus_rdata (loads), go to DONE; bus_req falls the next cycle.
REQ-016 DONE: done=1, stall=0, rdata valid; inputs ignored; next state IDLE unconditionally.
REQ-017 Minimum latency: request cycle N, bus_req high N+1, ack at N+1 -> done at N+2.
REQ-018 bus_be: byte 0001<<addr[1:0]; half 0011<<(addr[1]*2); word 1111.
REQ-019 bus_wdata: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
REQ-020 rdata: selected lane shifted to bit 0; bits above width filled with lane MSB if ext_os=1, else 0; word unchanged.
REQ-021 rdata SHALL hold its value until the next completed load; stores SHALL NOT change rdata.

Reset
REQ-022 rst_n=0 SHALL force, immediately and regardless of clock: state IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, rdata=0, done=0, err=0; stall=0.
REQ-023 Reset in REQ SHALL abandon the transaction; a late bus_ack after reset release in IDLE SHALL be ignored.

Configuration
REQ-024 Macro LSU_MISALIGN_TRAP_EN defined: misaligned half/word -> err pulse, no bus transaction (as REQ-012).
REQ-025 Macro undefined: misaligned access proceeds with addr[0] (half) or addr[1:0] (word) treated as 0; err only for REQ-012 cases.

Structure
REQ-026 Width encodings (WIDTH_W=00, WIDTH_H=01, WIDTH_B=10, WIDTH_INV=11) and the FSM state enum SHALL live in the shared defines package next to the ALU opcodes.
REQ-027 Lane steering (REQ-018..020) SHALL be a combinational sub-module lsu_align; FSM and registers in lsu.

Verification
REQ-028 lw addr=0x100, ack same cycle as req, bus_rdata=0xDEADBEEF -> bus_be=1111, bus_addr=0x100, done 2 cycles after request, rdata=0xDEADBEEF.
REQ-029 lb addr=0x103 ext_os=1, bus_rdata=0x80FF_0000 -> bus_be=1000, rdata=0xFFFFFF80; same with ext_os=0 -> rdata=0x00000080.
REQ-030 sh addr=0x202 wdata=0x0000ABCD, ack delayed 3 cycles -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD stable and stall=1 for all 4 REQ cycles, then done.
REQ-031 lw addr=0x101 -> with LSU_MISALIGN_TRAP_EN: err=1, bus_req never rises; without: bus_addr=0x100, bus_be=1111.
REQ-032 mem_read=mem_write=1, or mem_cut=11 -> err pulse, no bus_req.
REQ-033 rst_n low while in REQ -> bus_req=0 same cycle; ack after release ignored, state IDLE, done stays 0.
